// File: rtl/ccff_chain_loader.sv
// Configuration chain loader: serializes stream words MSB-first onto the ccff chain head
// with a registered shift enable, and returns the bits falling out of the tail as readback words.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 1024,
  parameter  int WORD_W    = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_sr;
  logic [WC_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]  r_tot;
  logic [WORD_W-1:0] r_rb_sr;
  logic [WC_W-1:0]   r_rb_cnt;
  logic              r_head, r_clk_en, r_rb_valid;
  logic [WORD_W-1:0] r_rb_data;

  logic [CNT_W-1:0]  w_tot_nxt;
  logic              w_last, w_word_end, w_more, w_flush;
  logic [WORD_W-1:0] w_rb_next, w_rb_just, w_rb_part;
  logic [WC_W-1:0]   w_rb_n;

  assign w_tot_nxt  = r_tot + CNT_W'(1);
  assign w_last     = (w_tot_nxt == CNT_W'(CHAIN_LEN));
  assign w_word_end = (r_wcnt == WC_W'(1));
  assign w_more     = ~abort & ~w_last & ~w_word_end;

  // Tail bits enter at the LSB; emitted words are left-justified so the first-out bit is the MSB.
  assign w_rb_next  = (r_rb_sr << 1) | WORD_W'(ccff_tail);
  assign w_rb_n     = r_rb_cnt + WC_W'(1);
  assign w_flush    = (w_rb_n == WC_W'(WORD_W)) | w_last | abort;
  assign w_rb_just  = w_rb_next << (WC_W'(WORD_W) - w_rb_n);
  assign w_rb_part  = r_rb_sr << (WC_W'(WORD_W) - r_rb_cnt);

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start && !abort)     w_state_nxt = FETCH;
      FETCH: if (abort)               w_state_nxt = DONE;
             else if (s_valid)        w_state_nxt = SHIFT;
      SHIFT: if (abort || w_last)     w_state_nxt = DONE;
             else if (w_word_end)     w_state_nxt = FETCH;
      DONE:                           w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (r_state == FETCH);
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_sr       <= '0;
      r_wcnt     <= '0;
      r_tot      <= '0;
      r_rb_sr    <= '0;
      r_rb_cnt   <= '0;
      r_head     <= 1'b0;
      r_clk_en   <= 1'b0;
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      case (r_state)
        IDLE: if (start && !abort) begin
          r_tot    <= '0;
          r_rb_sr  <= '0;
          r_rb_cnt <= '0;
        end
        FETCH: if (abort) begin
          if (r_rb_cnt != '0) begin
            r_rb_data  <= w_rb_part;
            r_rb_valid <= 1'b1;
          end
          r_rb_sr  <= '0;
          r_rb_cnt <= '0;
        end else if (s_valid) begin
          // First bit goes out on the accept edge so the chain sees it next cycle.
          r_head   <= s_data[WORD_W-1];
          r_sr     <= s_data << 1;
          r_wcnt   <= WC_W'(WORD_W);
          r_clk_en <= 1'b1;
        end
        SHIFT: begin
          r_tot  <= w_tot_nxt;
          r_wcnt <= r_wcnt - WC_W'(1);
          if (w_flush) begin
            r_rb_data  <= w_rb_just;
            r_rb_valid <= 1'b1;
            r_rb_sr    <= '0;
            r_rb_cnt   <= '0;
          end else begin
            r_rb_sr  <= w_rb_next;
            r_rb_cnt <= w_rb_n;
          end
          if (w_more) begin
            r_head <= r_sr[WORD_W-1];
            r_sr   <= r_sr << 1;
          end else begin
            r_clk_en <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ccff_head   = r_head;
  assign ccff_clk_en = r_clk_en;
  assign rb_valid    = r_rb_valid;
  assign rb_data     = r_rb_data;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: two instances (4-bit and 6-bit chains, 4-bit words)
// driving behavioural chain models; head bits and readback words are predicted from the models.
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [3:0] s_data = '0;

  logic       rdy_a, head_a, en_a, tail_a, rbv_a, busy_a, done_a;
  logic       rdy_b, head_b, en_b, tail_b, rbv_b, busy_b, done_b;
  logic [3:0] rbd_a, rbd_b;

  logic [3:0] chain_a = '0;
  logic [5:0] chain_b = '0;

  int n_chk = 0, n_err = 0;
  int sh_a = 0, sh_b = 0, rbn_a = 0, rbn_b = 0, dn_a = 0, dn_b = 0;
  logic [3:0] last_rb_a = '0, last_rb_b = '0;
  logic prev_en_a = 1'b0, prev_en_b = 1'b0;
  logic hq_a[$], hq_b[$];
  logic [3:0] rbq_a[$], rbq_b[$];

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(4)) u_a (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start_a), .abort(abort),
    .s_valid(s_valid), .s_ready(rdy_a), .s_data(s_data),
    .ccff_head(head_a), .ccff_clk_en(en_a), .ccff_tail(tail_a),
    .rb_valid(rbv_a), .rb_data(rbd_a), .busy(busy_a), .done(done_a));

  ccff_chain_loader #(.CHAIN_LEN(6), .WORD_W(4)) u_b (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start_b), .abort(abort),
    .s_valid(s_valid), .s_ready(rdy_b), .s_data(s_data),
    .ccff_head(head_b), .ccff_clk_en(en_b), .ccff_tail(tail_b),
    .rb_valid(rbv_b), .rb_data(rbd_b), .busy(busy_b), .done(done_b));

  // Chain models: bit 0 is nearest the head, the top bit feeds the tail.
  assign tail_a = chain_a[3];
  assign tail_b = chain_b[5];
  always @(posedge clk) begin
    if (en_a) chain_a <= {chain_a[2:0], head_a};
    if (en_b) chain_b <= {chain_b[4:0], head_b};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (en_a) begin
        sh_a++;
        if (hq_a.size() == 0) chk("head_a_extra", 1, 0);
        else chk("head_a", head_a, hq_a.pop_front());
      end
      if (rbv_a) begin
        rbn_a++; last_rb_a = rbd_a;
        if (rbq_a.size() == 0) chk("rb_a_extra", 1, 0);
        else chk("rb_a", rbd_a, rbq_a.pop_front());
      end
      if (done_a) begin dn_a++; chk("done_after_shift_a", prev_en_a, 1); end
      chk("sready_a_excl", rdy_a & (en_a | ~busy_a), 0);
      if (en_b) begin
        sh_b++;
        if (hq_b.size() == 0) chk("head_b_extra", 1, 0);
        else chk("head_b", head_b, hq_b.pop_front());
      end
      if (rbv_b) begin
        rbn_b++; last_rb_b = rbd_b;
        if (rbq_b.size() == 0) chk("rb_b_extra", 1, 0);
        else chk("rb_b", rbd_b, rbq_b.pop_front());
      end
      if (done_b) begin dn_b++; chk("done_after_shift_b", prev_en_b, 1); end
      chk("sready_b_excl", rdy_b & (en_b | ~busy_b), 0);
    end
    prev_en_a = en_a;
    prev_en_b = en_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Predict readback of the next n shifted-out bits from the current chain contents.
  task automatic push_rb(input bit b, input int n);
    logic [5:0] c; logic [3:0] w; int len, k;
    c = b ? chain_b : {2'b00, chain_a};
    len = b ? 6 : 4; w = '0; k = 0;
    for (int i = 0; i < n; i++) begin
      w[3-k] = c[len-1-i]; k++;
      if (k == 4 || i == n - 1) begin
        if (b) rbq_b.push_back(w); else rbq_a.push_back(w);
        w = '0; k = 0;
      end
    end
  endtask

  task automatic push_h(input bit b, input logic [3:0] w, input int n);
    for (int i = 0; i < n; i++)
      if (b) hq_b.push_back(w[3-i]); else hq_a.push_back(w[3-i]);
  endtask

  task automatic send(input logic [3:0] w);
    int t = 0;
    s_valid = 1'b1; s_data = w;
    @(negedge clk);
    while (!(rdy_a | rdy_b) && t < 50) begin @(negedge clk); t++; end
    chk("accept_timeout", t < 50, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input bit b);
    int t = 0;
    @(negedge clk);
    while (!(b ? done_b : done_a) && t < 50) begin @(negedge clk); t++; end
    chk("done_timeout", t < 50, 1);
    @(negedge clk);
    chk("busy_after_done", b ? busy_b : busy_a, 0);
    chk("hq_empty", b ? hq_b.size() : hq_a.size(), 0);
    chk("rbq_empty", b ? rbq_b.size() : rbq_a.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    tick(1);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    int s0, r0, d0;
    tick(3);
    chk("rst_ready", {rdy_a, rdy_b}, 0);
    chk("rst_en", {en_a, en_b}, 0);
    chk("rst_head", {head_a, head_b}, 0);
    chk("rst_busy_done", {busy_a, busy_b, done_a, done_b}, 0);
    chk("rst_rb", {rbv_a, rbv_b, rbd_a, rbd_b}, 0);
    rst_n = 1'b1;
    tick(2);

    // 4-bit chain, word 1010 over an all-zero chain
    push_rb(0, 4); push_h(0, 4'b1010, 4);
    s0 = sh_a; r0 = rbn_a; d0 = dn_a;
    pulse_start(0); send(4'b1010); wait_done(0);
    chk("t1_shifts", sh_a - s0, 4);
    chk("t1_chain", chain_a, 4'b1010);
    chk("t1_rb_cnt", rbn_a - r0, 1);
    chk("t1_rb", last_rb_a, 4'b0000);
    chk("t1_done_cnt", dn_a - d0, 1);

    // Second load shows readback ordering
    push_rb(0, 4); push_h(0, 4'b0110, 4);
    pulse_start(0); send(4'b0110); wait_done(0);
    chk("t2_rb", last_rb_a, 4'b1010);
    chk("t2_chain", chain_a, 4'b0110);

    // 6-bit chain, two words; a start pulse while busy must be ignored
    push_rb(1, 6); push_h(1, 4'b1100, 4); push_h(1, 4'b1011, 2);
    s0 = sh_b; r0 = rbn_b;
    pulse_start(1); send(4'b1100);
    pulse_start(1);
    send(4'b1011); wait_done(1);
    chk("t3_shifts", sh_b - s0, 6);
    chk("t3_rb_cnt", rbn_b - r0, 2);
    chk("t3_chain", chain_b, 6'b110010);

    // Stall between words; previous contents return as 1100 then 10 left-justified
    push_rb(1, 6); push_h(1, 4'b0011, 4); push_h(1, 4'b0101, 2);
    s0 = sh_b;
    pulse_start(1); send(4'b0011);
    begin
      int t = 0;
      @(negedge clk);
      while (!rdy_b && t < 50) begin @(negedge clk); t++; end
      chk("t4_fetch_timeout", t < 50, 1);
    end
    r0 = sh_b;
    repeat (5) begin
      chk("t4_stall_en", en_b, 0);
      @(negedge clk);
    end
    chk("t4_stall_shifts", sh_b - r0, 0);
    @(posedge clk); #1;
    send(4'b0101); wait_done(1);
    chk("t4_shifts", sh_b - s0, 6);
    chk("t4_rb_last", last_rb_b, 4'b1000);

    // start and abort together in IDLE: abort wins
    start_b = 1'b1; abort = 1'b1; tick(1); start_b = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy_b, 0);

    // Abort after 3 shifts
    push_rb(1, 3); push_h(1, 4'b1110, 3);
    s0 = sh_b; r0 = rbn_b; d0 = dn_b;
    pulse_start(1); send(4'b1110);
    tick(2); abort = 1'b1; tick(1); abort = 1'b0;
    wait_done(1);
    chk("t5_shifts", sh_b - s0, 3);
    chk("t5_rb_cnt", rbn_b - r0, 1);
    chk("t5_rb", last_rb_b, 4'b0010);
    chk("t5_done_cnt", dn_b - d0, 1);

    // Clean restart after abort
    push_rb(1, 6); push_h(1, 4'b1001, 4); push_h(1, 4'b0100, 2);
    s0 = sh_b;
    pulse_start(1); send(4'b1001); send(4'b0100); wait_done(1);
    chk("t5_restart_shifts", sh_b - s0, 6);

    // Reset mid-shift clears immediately
    push_h(0, 4'b1111, 4);
    pulse_start(0); send(4'b1111); tick(1);
    chk("t6_pre_en", en_a, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_en", en_a, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_rbv", rbv_a, 0);
    hq_a.delete(); rbq_a.delete();
    tick(2); rst_n = 1'b1; tick(1);
    push_rb(0, 4); push_h(0, 4'b0101, 4);
    s0 = sh_a;
    pulse_start(0); send(4'b0101); wait_done(0);
    chk("t6_fresh_shifts", sh_a - s0, 4);
    chk("t6_chain", chain_a, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
